// File: rtl/i2s_transmitter.sv
// ============================================================================
// i2s_transmitter
// ----------------------------------------------------------------------------
// I2S master transmitter at the output end of the audio path. Derives the bit
// clock (o_bclk) and word select (o_lrclk) from clk. It accepts one stereo
// frame {left,right} per frame period through a valid/ready handshake into a
// one-deep holding register. The frame is serialised MSB-first in standard
// I2S format, with data delayed one bit clock after each o_lrclk edge.
//
// Parameters
//   CLK_DIV       clk cycles per o_bclk half-period (>= 1)
//   SAMPLE_WIDTH  bits per channel slot; one frame = 2*SAMPLE_WIDTH bclk periods
//
// Ports
//   clk              system clock (single domain)
//   rst              asynchronous, active-high reset
//   i_left/i_right   two's-complement samples for the next frame
//   i_valid          frame offered
//   o_ready          holding register empty; transfer on i_valid && o_ready
//   o_bclk           bit clock, period 2*CLK_DIV clk
//   o_lrclk          word select: 0 = left slot, 1 = right slot
//   o_sdata          serial data; changes only on the o_bclk falling edge
//   o_frameStart     one-clk pulse on the clk where bit period 0 begins
//   o_underrunCount  (only with I2S_UNDERRUN_CNT_EN) saturating count of
//                    frame loads that found the holding register empty
//
// Optional feature macro: I2S_UNDERRUN_CNT_EN
//   Defined   -> adds o_underrunCount.
//   Undefined -> no counter; underruns silently replay the last frame.
// ============================================================================
module i2s_transmitter #(
    parameter int CLK_DIV      = 4,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] i_left,
    input  logic [SAMPLE_WIDTH-1:0] i_right,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic                    o_bclk,
    output logic                    o_lrclk,
    output logic                    o_sdata,
`ifdef I2S_UNDERRUN_CNT_EN
    output logic                    o_frameStart,
    output logic [15:0]             o_underrunCount
`else
    output logic                    o_frameStart
`endif
);

    localparam int W      = SAMPLE_WIDTH;
    localparam int FW     = 2 * SAMPLE_WIDTH;
    localparam int IDX_W  = $clog2(FW);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FW - 1);
    localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(W);
    localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(CLK_DIV - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] divCntReg;
    logic             bclkReg;
    logic [IDX_W-1:0] bitIdxReg;
    logic             lrclkReg;
    logic             sdataReg;
    logic             frameStartReg;
    logic             readyReg;       // 1 = holding register empty
    logic [FW-1:0]    holdReg;        // {left,right} waiting for the next frame
    logic [FW-1:0]    shiftReg;       // frame on the wire, MSB leaves first
    logic [FW-1:0]    lastFrameReg;   // replayed when the source underruns

    // ------------------------------------------------------------------------
    // Timing decode
    // ------------------------------------------------------------------------
    logic             divTerm;
    logic             bclkFall;
    logic             frameLoad;
    logic             accept;
    logic [IDX_W-1:0] bitIdxNext;

    always_comb begin
        divTerm    = (divCntReg == DIV_TC);
        // The divider toggles bclk at terminal count; toggling while high
        // is the falling edge, where every serial output advances.
        bclkFall   = divTerm && bclkReg;
        bitIdxNext = (bitIdxReg == LAST_IDX) ? '0 : bitIdxReg + IDX_W'(1);
        // Wrapping back to period 0 is the frame boundary.
        frameLoad  = bclkFall && (bitIdxReg == LAST_IDX);
        accept     = i_valid && readyReg;
    end

    // ------------------------------------------------------------------------
    // Bit clock, word select, serialiser and holding register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divCntReg     <= '0;
            bclkReg       <= 1'b0;
            bitIdxReg     <= LAST_IDX;
            lrclkReg      <= 1'b1;
            sdataReg      <= 1'b0;
            frameStartReg <= 1'b0;
            readyReg      <= 1'b1;
            holdReg       <= '0;
            shiftReg      <= '0;
            lastFrameReg  <= '0;
        end else begin
            frameStartReg <= frameLoad;

            if (divTerm) begin
                divCntReg <= '0;
                bclkReg   <= ~bclkReg;
            end else begin
                divCntReg <= divCntReg + DIV_W'(1);
            end

            if (bclkFall) begin
                bitIdxReg <= bitIdxNext;
                lrclkReg  <= (bitIdxNext >= HALF_IDX);
                // The shifter's MSB always holds the bit owed to the period
                // being entered. On entering period 0 that is still the old
                // frame's right[0], which gives the one-bclk I2S data delay
                // for free before the new frame is loaded.
                sdataReg  <= shiftReg[FW-1];
                if (frameLoad) begin
                    if (!readyReg) begin
                        shiftReg     <= holdReg;
                        lastFrameReg <= holdReg;
                    end else begin
                        shiftReg     <= lastFrameReg;
                    end
                end else begin
                    shiftReg <= {shiftReg[FW-2:0], 1'b0};
                end
            end

            // A load only drains a holding register that was already full
            // before this clk. A frame accepted on the load clk itself waits
            // for the following frame, so the load branch must not bypass it.
            if (frameLoad && !readyReg) begin
                readyReg <= 1'b1;
            end else if (accept) begin
                holdReg  <= {i_left, i_right};
                readyReg <= 1'b0;
            end
        end
    end

    assign o_bclk       = bclkReg;
    assign o_lrclk      = lrclkReg;
    assign o_sdata      = sdataReg;
    assign o_ready      = readyReg;
    assign o_frameStart = frameStartReg;

`ifdef I2S_UNDERRUN_CNT_EN
    // ------------------------------------------------------------------------
    // Underrun counter: a load that finds the holding register empty
    // replays the last frame and is counted here, saturating at all-ones.
    // ------------------------------------------------------------------------
    logic [15:0] underrunCountReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrunCountReg <= '0;
        end else if (frameLoad && readyReg && (underrunCountReg != 16'hFFFF)) begin
            underrunCountReg <= underrunCountReg + 16'd1;
        end
    end

    assign o_underrunCount = underrunCountReg;
`endif

endmodule
